// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {S_FETCH, S_DRAIN} fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          PC_INCR   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush; flush and reset both empty it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, credit-limited imem requests, {pc, instr}
// buffer and redirect handling that discards wrong-path responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       FIFO_DEPTH    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     imem_req_o,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [31:0]              imem_rdata_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [31:0]              instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  input  logic                     pcsrc_i,
  input  logic [ADDRESS_WIDTH-1:0] branch_target_i
);

  localparam int          AW      = ADDRESS_WIDTH;
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam int          BW      = AW + 32;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] inflight, buf_count;
  logic [CW:0]   credit_used;
  logic [BW-1:0] buf_head;
  logic [AW-1:0] aq_head;
  logic          buf_full, buf_empty, aq_full, aq_empty;
  logic          issue, rsp, buf_push, buf_pop;

  // A pop this cycle frees a slot immediately, which is what sustains one fetch per cycle.
  assign buf_pop     = instr_valid_o & instr_ready_i;
  assign credit_used = {1'b0, inflight} + {1'b0, buf_count} - {{CW{1'b0}}, buf_pop};
  assign imem_req_o  = ~rst_i & ~pcsrc_i & (state_q == S_FETCH) & (credit_used < DEPTH_W);
  assign imem_addr_o = pc_q;
  assign issue       = imem_req_o & imem_gnt_i;
  assign rsp         = imem_rvalid_i;
  assign buf_push    = rsp & (state_q == S_FETCH) & (discard_q == '0) & ~pcsrc_i;

  fetch_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (pcsrc_i),
    .data_i  ({aq_head, imem_rdata_i}),
    .data_o  (buf_head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // Address queue occupancy doubles as the in-flight counter, stale requests included.
  fetch_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_aq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .pop_i   (rsp),
    .flush_i (1'b0),
    .data_i  (pc_q),
    .data_o  (aq_head),
    .count_o (inflight),
    .full_o  (aq_full),
    .empty_o (aq_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if (issue) pc_d = pc_q + AW'(PC_INCR);
    if (pcsrc_i) begin
      pc_d      = branch_target_i & ~AW'(3);
      discard_d = inflight - CW'(rsp);
      state_d   = (discard_d != '0) ? S_DRAIN : S_FETCH;
    end else if (state_q == S_DRAIN && rsp) begin
      discard_d = discard_q - CW'(1);
      if (discard_d == '0) state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  assign instr_valid_o = ~buf_empty;
  assign instr_o       = buf_empty ? NOP_INSTR : buf_head[31:0];
  assign pc_o          = buf_empty ? pc_q : buf_head[BW-1:32];

  a_no_rsp_underflow: assert property (@(posedge clk_i) disable iff (rst_i) rsp |-> !aq_empty);
  a_no_aq_overflow:   assert property (@(posedge clk_i) disable iff (rst_i) issue |-> !aq_full);
  a_no_buf_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) buf_push |-> !buf_full);
  a_discard_bounded:  assert property (@(posedge clk_i) disable iff (rst_i) discard_q <= inflight);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable imem model feeds responses and
// expected {pc, instr} pairs are queued at issue and checked on every pop.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, gnt, rvalid, ready, pcsrc;
  logic [31:0] rdata, target;
  logic        req, ivld;
  logic [31:0] addr, instr, pc;

  fetch_unit #(.ADDRESS_WIDTH(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_gnt_i      (gnt),
    .imem_rvalid_i   (rvalid),
    .imem_rdata_i    (rdata),
    .instr_valid_o   (ivld),
    .instr_ready_i   (ready),
    .instr_o         (instr),
    .pc_o            (pc),
    .pcsrc_i         (pcsrc),
    .branch_target_i (target)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] mpc;
  int          due_q[$];
  logic [31:0] raddr_q[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];
  logic [31:0] iss_q[$];
  int          iss_cyc_q[$];
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[17:2]} ^ 32'h5A5A_0013;
  endfunction

  // One clock cycle: sample outputs, update the model, advance, drive the next response.
  task automatic tick();
    #1;
    s_req = req; s_addr = addr; s_valid = ivld; s_pc = pc; s_instr = instr;
    if (rst) begin
      exp_pc.delete(); exp_ins.delete(); mpc = RESET_PC;
    end else begin
      if (ivld && ready) begin
        vectors++;
        if (exp_pc.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected: pc_o=%h instr_o=%h, required no valid instruction", pc, instr);
        end else begin
          if (pc !== exp_pc[0] || instr !== exp_ins[0]) begin
            miscompares++;
            $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                     pc, instr, exp_pc[0], exp_ins[0]);
          end
          void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
        end
      end
      if (req && gnt) begin
        vectors++;
        if (addr !== mpc) begin
          miscompares++;
          $display("FAIL issue_addr: imem_addr_o=%h, required %h", addr, mpc);
        end
        due_q.push_back(cyc + lat); raddr_q.push_back(addr);
        exp_pc.push_back(mpc); exp_ins.push_back(mem_word(mpc));
        iss_q.push_back(addr); iss_cyc_q.push_back(cyc);
        mpc = mpc + 32'd4;
      end
      if (pcsrc) begin
        exp_pc.delete(); exp_ins.delete(); mpc = target & ~32'h3;
      end
    end
    @(posedge clk); @(negedge clk); cyc++;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      rvalid = 1'b1; rdata = mem_word(raddr_q[0]);
      void'(due_q.pop_front()); void'(raddr_q.pop_front());
    end else begin
      rvalid = 1'b0; rdata = $urandom;
    end
  endtask

  task automatic settle();
    gnt = 1'b0; ready = 1'b1; pcsrc = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt = 1'b1; ready = 1'b1; pcsrc = 1'b0; lat = 1;
    tick(); tick();
    vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b, required 0", s_req); end
    vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", s_valid); end
    vectors++; if (s_instr !== NOP) begin miscompares++; $display("FAIL rst_instr: got %h, required %h", s_instr, NOP); end
    vectors++; if (s_pc !== RESET_PC) begin miscompares++; $display("FAIL rst_pc: got %h, required %h", s_pc, RESET_PC); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic v[10];
    int c0, nv;
    iss_q.delete(); iss_cyc_q.delete(); c0 = cyc;
    for (int i = 0; i < 10; i++) begin tick(); v[i] = s_valid; end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (iss_q.size() <= k || iss_q[k] !== 32'(4 * k) || iss_cyc_q[k] != c0 + k) begin
        miscompares++;
        $display("FAIL stream_issue%0d: %0d issues logged, required addr %h at cycle offset %0d", k, iss_q.size(), 32'(4 * k), k);
      end
    end
    vectors++; if (v[0] !== 1'b0 || v[1] !== 1'b0) begin miscompares++; $display("FAIL stream_startup: valid %b%b in first two cycles, required 00", v[0], v[1]); end
    nv = 0;
    for (int i = 2; i < 10; i++) if (v[i] === 1'b1) nv++;
    vectors++; if (nv != 8) begin miscompares++; $display("FAIL stream_throughput: %0d valid cycles of 8, required 8", nv); end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] hold;
    hold = mpc; gnt = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (s_req !== 1'b1 || s_addr !== hold) begin
        miscompares++; $display("FAIL stall_hold%0d: req=%b addr=%h, required req=1 addr=%h", i, s_req, s_addr, hold);
      end
    end
    gnt = 1'b1; iss_q.delete();
    tick();
    vectors++; if (iss_q.size() != 1 || iss_q[0] !== hold) begin miscompares++; $display("FAIL stall_grant: %0d issues, required 1 at %h", iss_q.size(), hold); end
  endtask

  task automatic test_back_pressure();
    int nreq_late;
    settle();
    gnt = 1'b1; ready = 1'b0; iss_q.delete(); nreq_late = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 2 && s_req === 1'b1) nreq_late++;
    end
    vectors++; if (iss_q.size() != 2) begin miscompares++; $display("FAIL bp_issues: %0d issued, required 2", iss_q.size()); end
    vectors++; if (nreq_late != 0) begin miscompares++; $display("FAIL bp_req_idle: req high %0d cycles after credits used, required 0", nreq_late); end
    ready = 1'b1;
    repeat (8) tick();
    settle();
    vectors++; if (exp_pc.size() != 0) begin miscompares++; $display("FAIL bp_no_loss: %0d expected entries never delivered, required 0", exp_pc.size()); end
  endtask

  task automatic test_redirect_drain();
    logic found;
    settle();
    lat = 3; gnt = 1'b1; ready = 1'b1;
    tick(); tick();
    pcsrc = 1'b1; target = 32'h103;
    tick();
    pcsrc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (s_req !== 1'b0 || s_valid !== 1'b0) begin
        miscompares++; $display("FAIL drain_quiet%0d: req=%b valid=%b, required 0 0", i, s_req, s_valid);
      end
    end
    tick();
    vectors++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin miscompares++; $display("FAIL drain_resume: req=%b addr=%h, required 1 00000100", s_req, s_addr); end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin tick(); if (s_valid === 1'b1) found = 1'b1; end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL drain_first_pc: no valid within 8 cycles, required pc 00000100"); end
    else if (s_pc !== 32'h100) begin miscompares++; $display("FAIL drain_first_pc: got %h, required 00000100", s_pc); end
  endtask

  task automatic test_redirect_pop();
    settle();
    lat = 1; gnt = 1'b1; ready = 1'b1;
    repeat (3) tick();
    pcsrc = 1'b1; target = 32'h200;
    tick();
    vectors++; if (s_valid !== 1'b1) begin miscompares++; $display("FAIL rp_pop_cycle: valid=%b in redirect cycle, required 1", s_valid); end
    pcsrc = 1'b0;
    tick();
    vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("FAIL rp_flushed: valid=%b after redirect, required 0", s_valid); end
    vectors++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin miscompares++; $display("FAIL rp_target: req=%b addr=%h, required 1 00000200", s_req, s_addr); end
    repeat (5) tick();
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 2; k++) begin
      settle();
      lat = (k == 0) ? 3 : 1; gnt = 1'b1; ready = 1'b0;
      repeat ((k == 0) ? 2 : 4) tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (i >= 1) begin
          vectors++;
          if (s_req !== 1'b0 || s_valid !== 1'b0 || s_instr !== NOP || s_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL midrst%0d_state%0d: req=%b valid=%b instr=%h pc=%h, required 0 0 %h %h",
                     k, i, s_req, s_valid, s_instr, s_pc, NOP, RESET_PC);
          end
        end
      end
      rst = 1'b0; ready = 1'b1;
      tick();
      vectors++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin miscompares++; $display("FAIL midrst%0d_first: req=%b addr=%h, required 1 %h", k, s_req, s_addr, RESET_PC); end
      repeat (6) tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want[4];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0; want[3] = 32'h4;
    settle();
    lat = 1; gnt = 1'b1; ready = 1'b1; iss_q.delete();
    pcsrc = 1'b1; target = 32'hFFFF_FFF9;
    tick();
    vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL wrap_suppress: req=%b in redirect cycle, required 0", s_req); end
    pcsrc = 1'b0;
    repeat (6) tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (iss_q.size() <= k || iss_q[k] !== want[k]) begin
        miscompares++; $display("FAIL wrap_addr%0d: %0d issues logged, required %h", k, iss_q.size(), want[k]);
      end
    end
    settle();
  endtask

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0; pcsrc = 1'b0; target = '0;
    mpc = RESET_PC;
    @(negedge clk);
    test_reset();
    test_stream();
    test_gnt_stall();
    test_back_pressure();
    test_redirect_drain();
    test_redirect_pop();
    test_reset_midop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary, required completion");
    $fatal(1, "watchdog");
  end

endmodule
